uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command sequencer between a UART byte receiver, a register bank and a UART byte transmitter.
- Consumes the received byte stream (data plus one-cycle valid pulse) and frames it into write or read commands.
- Issues register write/read strobes, then sequences the response bytes into the transmitter with a start/busy handshake.
- Provides the host-side register access path for the board.

Parameters:
- DATA_BYTES, 2: payload bytes per register word; register data width = 8*DATA_BYTES.
- SYNC_BYTE, 8'hA5: frame start marker, used for both commands and read responses.
- ACK_BYTE, 8'h06: response to a successful write.
- NAK_BYTE, 8'h15: response to a bad checksum or a read timeout.
- TIMEOUT_CLKS, 10000: maximum clocks between received bytes inside a frame, and maximum clocks waiting for read data.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, active-low, asynchronous assert; all state and outputs reset on rst==0
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse; rx_data valid this cycle
- reg_addr  out  7  register address
- reg_wdata  out  8*DATA_BYTES  write data
- reg_wr_en  out  1  one-cycle write strobe
- reg_rd_en  out  1  one-cycle read strobe
- reg_rdata  in  8*DATA_BYTES  read data
- reg_rd_valid  in  1  read data valid; arrives any number of cycles after reg_rd_en
- tx_byte  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- busy  out  1  high whenever state != IDLE
- err_chk  out  1  one-cycle pulse on checksum mismatch
- err_timeout  out  1  one-cycle pulse on inter-byte or read timeout
- err_ovr  out  1  one-cycle pulse when rx_valid is dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Command frame: SYNC, CMD, then DATA_BYTES data bytes MSB first (write only), then CHK.
- CMD byte: bit7 = 1 means read, 0 means write; bits6:0 = reg_addr.
- CHK = XOR of CMD and all data bytes. A read frame therefore has CHK == CMD.
- States: IDLE, CMD, DATA, CHK, EXEC_WR, RD_REQ, RD_WAIT, TX_LOAD, TX_WAIT.
- IDLE: stays in IDLE until rx_valid with rx_data==SYNC_BYTE, then goes to CMD. Any other byte is silently discarded.
- CMD: on rx_valid, latch addr/dir, seed the running XOR. Write goes to DATA with byte index=0; read goes to CHK.
- DATA: on each rx_valid, shift the byte into reg_wdata from the MSB side and XOR it in. After byte DATA_BYTES-1, go to CHK.
- CHK, match: write goes to EXEC_WR; read goes to RD_REQ.
- CHK, mismatch: err_chk pulse; queue a single NAK_BYTE; go to TX_LOAD.
- EXEC_WR: reg_wr_en=1 for exactly one cycle; queue ACK_BYTE; go to TX_LOAD.
- RD_REQ: reg_rd_en=1 for one cycle; go to RD_WAIT.
- RD_WAIT: on reg_rd_valid, latch reg_rdata and queue the response SYNC, data MSB first, CHK. CHK = XOR of the data bytes. Go to TX_LOAD.
- RD_WAIT timeout: after TIMEOUT_CLKS cycles without reg_rd_valid, err_timeout pulse and queue NAK_BYTE.
- TX_LOAD: when tx_busy==0, drive tx_byte and pulse tx_start for one cycle, then go to TX_WAIT.
- TX_WAIT: ignore tx_busy for the first cycle, then wait for tx_busy==0. If more bytes remain, return to TX_LOAD; otherwise go to IDLE.
- Timeout counter: cleared on every rx_valid and on every state entry. In CMD/DATA/CHK, reaching TIMEOUT_CLKS-1 gives err_timeout, IDLE, and no response.
- rx_valid in any state from EXEC_WR through TX_WAIT: byte dropped, err_ovr pulse.
- A SYNC_BYTE value inside DATA is treated as data, with no resynchronisation.
- rst low at any point, including mid-frame or mid-transmit: immediate return to IDLE, outputs cleared. A transmitter already in progress is not aborted by this block.
- reg_addr and reg_wdata hold their last values between commands.
- Response bytes come from a small internal byte queue of at most DATA_BYTES+2 entries.

Optional Feature:
- Macro UART_CMD_CHK_EN.
- Defined: behaviour exactly as above; the CHK byte is required in commands and appended to read responses.
- Undefined: no CHK byte in either direction. The last data byte (write) or the CMD byte (read) goes directly to EXEC_WR/RD_REQ. err_chk is tied to 0. Read response is SYNC plus data only.

Test Plan:
- Write, DATA_BYTES=2: A5 12 BE EF 43 -> one reg_wr_en cycle with reg_addr=7'h12, reg_wdata=16'hBEEF; tx bytes 06; busy returns low.
- Read: A5 85 85, reg_rd_valid 5 cycles later with 16'h1234 -> reg_rd_en with reg_addr=7'h05; tx bytes A5 12 34 26.
- Bad checksum: A5 12 BE EF 00 -> err_chk pulse, no reg_wr_en, tx byte 15.
- Timeout: A5 12 BE, then silence for TIMEOUT_CLKS -> err_timeout pulse, IDLE, no tx_start. A following valid frame is accepted normally.
- Overrun and backpressure: hold tx_busy=1 for 500 cycles after a write and inject rx_valid -> err_ovr pulse; tx_start only after tx_busy falls.
- Reset mid-DATA (rst=0 for 2 cycles) -> all outputs 0, busy=0. A subsequent write frame is executed correctly.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART rx bytes into register write/read commands and sequences tx responses.
// Define UART_CMD_CHK_EN to require the XOR checksum byte in commands and append it to read responses.
module uart_cmd_ctrl #(
   parameter int         DATA_BYTES   = 2,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter logic [7:0] ACK_BYTE     = 8'h06,
   parameter logic [7:0] NAK_BYTE     = 8'h15,
   parameter int         TIMEOUT_CLKS = 10000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [6:0]              reg_addr,
   output logic [8*DATA_BYTES-1:0] reg_wdata,
   output logic                    reg_wr_en,
   output logic                    reg_rd_en,
   input  logic [8*DATA_BYTES-1:0] reg_rdata,
   input  logic                    reg_rd_valid,
   output logic [7:0]              tx_byte,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    err_chk,
   output logic                    err_timeout,
   output logic                    err_ovr
);
`ifdef UART_CMD_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int W  = 8*DATA_BYTES;
   localparam int QB = W + 16;
   localparam int QW = $clog2(DATA_BYTES + 3);
   localparam int IW = $clog2(DATA_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CMD     = 4'd1;
   localparam logic [3:0] S_DATA    = 4'd2;
   localparam logic [3:0] S_CHK     = 4'd3;
   localparam logic [3:0] S_EXEC_WR = 4'd4;
   localparam logic [3:0] S_RD_REQ  = 4'd5;
   localparam logic [3:0] S_RD_WAIT = 4'd6;
   localparam logic [3:0] S_TX_LOAD = 4'd7;
   localparam logic [3:0] S_TX_WAIT = 4'd8;
   // Without the checksum the frame ends on the last data byte (write) or the CMD byte (read)
   localparam logic [3:0] S_WR_GO = CHK_EN ? S_CHK : S_EXEC_WR;
   localparam logic [3:0] S_RD_GO = CHK_EN ? S_CHK : S_RD_REQ;

   logic [3:0]    state, state_n;
   logic [TW-1:0] tmr;
   logic [IW-1:0] idx;
   logic          dir;
   logic [7:0]    xr, rd_x;
   logic [QB-1:0] qv;
   logic [QW-1:0] q_len;
   logic          tw_first;
   logic          in_frame, tmo, chk_ok, last, q_load, tx_fire;

   always_comb begin
      rd_x = '0;
      for (int i = 0; i < DATA_BYTES; i++) rd_x = rd_x ^ reg_rdata[8*i +: 8];
   end

   assign in_frame = state == S_CMD || state == S_DATA || state == S_CHK;
   assign tmo      = tmr == TW'(TIMEOUT_CLKS - 1) && (in_frame ? !rx_valid : state == S_RD_WAIT && !reg_rd_valid);
   assign chk_ok   = xr == rx_data;
   assign last     = idx == IW'(DATA_BYTES - 1);
   assign busy     = state != S_IDLE;
   assign tx_fire  = state == S_TX_LOAD && !tx_busy;
   assign q_load   = state == S_EXEC_WR || state == S_RD_WAIT && (reg_rd_valid || tmo) || state == S_CHK && rx_valid && !chk_ok;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    state_n = rx_valid && rx_data == SYNC_BYTE ? S_CMD : S_IDLE;
         S_CMD:     state_n = rx_valid ? (rx_data[7] ? S_RD_GO : S_DATA) : tmo ? S_IDLE : S_CMD;
         S_DATA:    state_n = rx_valid ? (last ? S_WR_GO : S_DATA) : tmo ? S_IDLE : S_DATA;
         S_CHK:     state_n = rx_valid ? (!chk_ok ? S_TX_LOAD : dir ? S_RD_REQ : S_EXEC_WR) : tmo ? S_IDLE : S_CHK;
         S_EXEC_WR: state_n = S_TX_LOAD;
         S_RD_REQ:  state_n = S_RD_WAIT;
         S_RD_WAIT: state_n = reg_rd_valid || tmo ? S_TX_LOAD : S_RD_WAIT;
         S_TX_LOAD: state_n = tx_busy ? S_TX_LOAD : S_TX_WAIT;
         S_TX_WAIT: state_n = tw_first || tx_busy ? S_TX_WAIT : q_len != '0 ? S_TX_LOAD : S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         tmr         <= '0;
         idx         <= '0;
         dir         <= 1'b0;
         xr          <= '0;
         qv          <= '0;
         q_len       <= '0;
         tw_first    <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_wr_en   <= 1'b0;
         reg_rd_en   <= 1'b0;
         tx_byte     <= '0;
         tx_start    <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         err_ovr     <= 1'b0;
      end else begin
         state       <= state_n;
         tmr         <= state_n != state || rx_valid ? '0 : tmr + TW'(1);
         tw_first    <= tx_fire;
         tx_start    <= tx_fire;
         reg_wr_en   <= state == S_EXEC_WR;
         reg_rd_en   <= state == S_RD_REQ;
         err_chk     <= CHK_EN && state == S_CHK && rx_valid && !chk_ok;
         err_timeout <= tmo;
         err_ovr     <= rx_valid && state >= S_EXEC_WR;
         if (rx_valid && state == S_CMD) begin
            reg_addr <= rx_data[6:0];
            dir      <= rx_data[7];
            xr       <= rx_data;
            idx      <= '0;
         end
         if (rx_valid && state == S_DATA) begin
            reg_wdata <= W'({reg_wdata, rx_data});
            xr        <= xr ^ rx_data;
            idx       <= idx + IW'(1);
         end
         // Response queue is a left-shifting byte register; q_len counts bytes still to send
         if (q_load) begin
            qv    <= state == S_RD_WAIT && reg_rd_valid ? {SYNC_BYTE, reg_rdata, rd_x} : {state == S_EXEC_WR ? ACK_BYTE : NAK_BYTE, {(W+8){1'b0}}};
            q_len <= state == S_RD_WAIT && reg_rd_valid ? QW'(CHK_EN ? DATA_BYTES + 2 : DATA_BYTES + 1) : QW'(1);
         end else if (tx_fire) begin
            tx_byte <= qv[QB-1 -: 8];
            qv      <= qv << 8;
            q_len   <= q_len - QW'(1);
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: table-driven command frames plus directed timeout, overrun, read-timeout and reset sequences.
module tb_uart_cmd_ctrl;
`ifdef UART_CMD_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr_en, reg_rd_en;
   logic [15:0] reg_rdata = '0;
   logic        reg_rd_valid = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic        busy, err_chk, err_timeout, err_ovr;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.DATA_BYTES(2), .TIMEOUT_CLKS(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
      .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
      .busy(busy), .err_chk(err_chk), .err_timeout(err_timeout), .err_ovr(err_ovr)
   );

   typedef struct {
      logic [39:0] frame;
      int          n;
      logic        wr;
      logic        rd;
      logic [6:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        bad;
      logic [31:0] tx;
      int          ntx;
   } vec_t;

   int n_chk = 0, n_err = 0;
   int wr_cnt, rd_cnt, chk_cnt, tmo_cnt, ovr_cnt;
   logic [6:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, rd_val;
   logic [7:0]  txq[$];
   bit rd_hold = 0, force_busy = 0;
   int rd_dly = 0, tx_dly = 0;

   // Register bank and transmitter models, sampled away from the active edge
   always @(negedge clk) begin
      if (reg_wr_en) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
      if (reg_rd_en) begin rd_cnt++; rd_addr = reg_addr; if (!rd_hold) rd_dly = 5; end
      if (err_chk) chk_cnt++;
      if (err_timeout) tmo_cnt++;
      if (err_ovr) ovr_cnt++;
      reg_rd_valid = 1'b0;
      if (rd_dly > 0) begin
         rd_dly--;
         if (rd_dly == 0) begin reg_rd_valid = 1'b1; reg_rdata = rd_val; end
      end
      if (tx_start) begin txq.push_back(tx_byte); tx_dly = 4; end
      else if (tx_dly > 0) tx_dly--;
      tx_busy = force_busy || tx_dly > 0;
   end

   task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
      end
   endtask

   task automatic clear();
      wr_cnt = 0; rd_cnt = 0; chk_cnt = 0; tmo_cnt = 0; ovr_cnt = 0;
      txq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk); rx_data = b; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [39:0] f, input int n);
      for (int i = 0; i < n; i++) send_byte(f[39-8*i -: 8]);
   endtask

   task automatic wait_idle(input string nm);
      int c = 0;
      while (busy && c < 3000) begin @(negedge clk); c++; end
      chk(nm, "busy_end", busy, 0);
   endtask

   task automatic apply(input vec_t v, input string nm);
      int n = CHK ? v.n : v.n - 1;
      int ntx = v.ntx;
      logic [31:0] tx = v.tx;
      logic wr = v.wr;
      logic bad = v.bad;
      if (!CHK && v.rd) ntx--;
      if (!CHK && bad) begin wr = 1'b1; bad = 1'b0; tx = 32'h0600_0000; ntx = 1; end
      clear();
      rd_val = v.rdata;
      send_frame(v.frame, n);
      wait_idle(nm);
      chk(nm, "wr_cnt", wr_cnt, wr);
      if (wr) begin
         chk(nm, "wr_addr", wr_addr, v.addr);
         chk(nm, "wr_data", wr_data, v.wdata);
      end
      chk(nm, "rd_cnt", rd_cnt, v.rd);
      if (v.rd) chk(nm, "rd_addr", rd_addr, v.addr);
      chk(nm, "err_chk", chk_cnt, bad);
      chk(nm, "tx_cnt", txq.size(), ntx);
      for (int i = 0; i < ntx; i++) chk(nm, "tx_byte", i < txq.size() ? txq[i] : 8'hxx, tx[31-8*i -: 8]);
   endtask

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{40'hA512BEEF43, 5, 1'b1, 1'b0, 7'h12, 16'hBEEF, 16'h0000, 1'b0, 32'h0600_0000, 1};
      vecs[1] = '{40'hA585850000, 3, 1'b0, 1'b1, 7'h05, 16'h0000, 16'h1234, 1'b0, 32'hA512_3426, 4};
      vecs[2] = '{40'hA512BEEF00, 5, 1'b0, 1'b0, 7'h12, 16'hBEEF, 16'h0000, 1'b1, 32'h1500_0000, 1};
      vecs[3] = '{40'hA57F00017E, 5, 1'b1, 1'b0, 7'h7F, 16'h0001, 16'h0000, 1'b0, 32'h0600_0000, 1};
      vecs[4] = '{40'hA580800000, 3, 1'b0, 1'b1, 7'h00, 16'h0000, 16'hFFFF, 1'b0, 32'hA5FF_FF00, 4};
      vecs[5] = '{40'hA501A5A501, 5, 1'b1, 1'b0, 7'h01, 16'hA5A5, 16'h0000, 1'b0, 32'h0600_0000, 1};
      clear();
      @(negedge clk);
      chk("reset", "outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_byte, tx_start, busy, err_chk, err_timeout, err_ovr}, 0);
      @(negedge clk); rst = 1'b1;
      send_byte(8'h3C);
      chk("idle_discard", "busy", busy, 0);
      for (int i = 0; i < 6; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Inter-byte timeout mid-DATA, then a normal frame
      clear();
      send_frame(40'hA512BE0000, 3);
      begin
         int c = 0;
         while (tmo_cnt == 0 && c < TMO + 100) begin @(negedge clk); c++; end
         chk("frame_tmo", "latency_ok", c >= TMO - 2 && c <= TMO + 2, 1);
      end
      chk("frame_tmo", "tmo_cnt", tmo_cnt, 1);
      chk("frame_tmo", "busy", busy, 0);
      repeat (10) @(negedge clk);
      chk("frame_tmo", "tx_cnt", txq.size(), 0);
      chk("frame_tmo", "wr_cnt", wr_cnt, 0);
      apply(vecs[0], "after_tmo");

      // Transmitter backpressure with an overrun byte
      clear();
      force_busy = 1;
      send_frame(40'hA512BEEF43, CHK ? 5 : 4);
      repeat (20) @(negedge clk);
      chk("ovr", "wr_cnt", wr_cnt, 1);
      send_byte(8'h55);
      repeat (2) @(negedge clk);
      chk("ovr", "ovr_cnt", ovr_cnt, 1);
      repeat (470) @(negedge clk);
      chk("ovr", "tx_held", txq.size(), 0);
      chk("ovr", "busy_held", busy, 1);
      force_busy = 0;
      wait_idle("ovr");
      chk("ovr", "tx_cnt", txq.size(), 1);
      chk("ovr", "tx_byte", txq.size() > 0 ? txq[0] : 8'hxx, 8'h06);

      // Read data never arrives
      clear();
      rd_hold = 1;
      send_frame(40'hA585850000, CHK ? 3 : 2);
      wait_idle("rd_tmo");
      rd_hold = 0;
      chk("rd_tmo", "rd_cnt", rd_cnt, 1);
      chk("rd_tmo", "tmo_cnt", tmo_cnt, 1);
      chk("rd_tmo", "tx_cnt", txq.size(), 1);
      chk("rd_tmo", "tx_byte", txq.size() > 0 ? txq[0] : 8'hxx, 8'h15);

      // Reset in the middle of DATA
      clear();
      send_frame(40'hA512BE0000, 3);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst", "outputs", {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_byte, tx_start, busy, err_chk, err_timeout, err_ovr}, 0);
      @(negedge clk);
      rst = 1'b1;
      apply(vecs[3], "after_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
